// File: rtl/huff_bitstream_sequencer.sv
// Feeds a Huffman tree walker one encoded bit per handshake, pulling bytes from an input FIFO
// once the dictionary is loaded. Define HUFF_MSB_FIRST_EN to serialize bytes MSB-first.
module huff_bitstream_sequencer #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             n_rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] total_bits_i,
    input  logic             dict_ready_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_r_en_o,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       state_o
);

    // Handshake: a bit moves on every clock where bit_valid_o & bit_ready_i are both high.
    // While bit_valid_o is high and bit_ready_i is low, bit_out_o and bit_valid_o hold steady.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DICT = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        SHIFT     = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic             fifo_r_en_q, fifo_r_en_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef HUFF_MSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] d);
        return d[7];
    endfunction

    function automatic logic [7:0] shift_byte(input logic [7:0] d);
        return {d[6:0], 1'b0};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] d);
        return d[0];
    endfunction

    function automatic logic [7:0] shift_byte(input logic [7:0] d);
        return {1'b0, d[7:1]};
    endfunction
`endif

    always_ff @(posedge clk_i) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            fifo_r_en_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            fifo_r_en_q <= fifo_r_en_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        fifo_r_en_d = 1'b0;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    if (total_bits_i != '0) begin
                        bits_left_d = total_bits_i;
                        state_d     = WAIT_DICT;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            WAIT_DICT: begin
                if (dict_ready_i) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (!fifo_empty_i) begin
                    fifo_r_en_d = 1'b1;
                    state_d     = LOAD;
                end
            end

            LOAD: begin
                shreg_d     = fifo_data_i;
                bcnt_d      = 4'd8;
                bit_out_d   = first_bit(fifo_data_i);
                bit_valid_d = 1'b1;
                state_d     = SHIFT;
            end

            SHIFT: begin
                if (bit_valid_q && bit_ready_i) begin
                    if (bits_left_q != '0) begin
                        bits_left_d = bits_left_q - CNT_W'(1);
                    end
                    if (bcnt_q != '0) begin
                        bcnt_d = bcnt_q - 4'd1;
                    end
                    // Stream end wins over byte end: pad bits of the final byte are dropped.
                    if (bits_left_q <= CNT_W'(1)) begin
                        bit_valid_d = 1'b0;
                        state_d     = FINISH;
                    end else if (bcnt_q <= 4'd1) begin
                        bit_valid_d = 1'b0;
                        state_d     = FETCH;
                    end else begin
                        shreg_d   = shift_byte(shreg_q);
                        bit_out_d = first_bit(shift_byte(shreg_q));
                    end
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_r_en_o = fifo_r_en_q;
    assign bit_out_o   = bit_out_q;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_huff_bitstream_sequencer.sv
// Directed bench for huff_bitstream_sequencer: FIFO model, bit scoreboard and handshake monitor.
module tb_huff_bitstream_sequencer;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] total_bits = '0;
    logic             dict_ready = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_data = '0;
    logic             fifo_r_en;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    huff_bitstream_sequencer #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .n_rst        (n_rst),
        .start_i      (start),
        .total_bits_i (total_bits),
        .dict_ready_i (dict_ready),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_r_en_o  (fifo_r_en),
        .bit_out_o    (bit_out),
        .bit_valid_o  (bit_valid),
        .bit_ready_i  (bit_ready),
        .busy_o       (busy),
        .done_o       (done),
        .state_o      (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO model and bit_ready driver ----------------
    logic [7:0] fifo_q[$];
    logic       force_empty = 1'b0;
    int         pop_req = 0;
    int         pop_done = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         ready_mode = 0;

    always @(posedge clk) begin
        logic new_empty;
        cyc++;
        #1;
        while (pop_done < pop_req) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_done++;
        end
        new_empty = force_empty || (fifo_q.size() == 0);
        if (fifo_empty && !new_empty) fall_cyc = cyc;
        fifo_empty = new_empty;
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        case (ready_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bit_ready = 1'b0;
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    logic [0:0] exp_q[$];
    int   xfers = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   first_xfer_cyc = 0;
    int   last_xfer_cyc = 0;
    int   last_rd_cyc = 0;
    int   done_cyc = 0;
    logic hold_armed = 1'b0;
    logic held_bit = 1'b0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (hold_armed && bit_valid) check("hold_stable", 32'(bit_out), 32'(held_bit));
            hold_armed = bit_valid && !bit_ready;
            held_bit   = bit_out;
            if (bit_valid && bit_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit", 32'(1), 32'(0));
                end else begin
                    check($sformatf("bit%0d", xfers), 32'(bit_out), 32'(exp_q.pop_front()));
                end
                if (xfers == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfers++;
            end
            if (fifo_r_en) begin
                rd_cnt++;
                pop_req++;
                last_rd_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_armed = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        exp_q.delete();
        xfers = 0;
        rd_cnt = 0;
        done_cnt = 0;
    endtask

    // Independent reference ordering: bit i of a byte as it should appear on the wire.
    function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef HUFF_MSB_FIRST_EN
        return b[7-i];
`else
        return b[i];
`endif
    endfunction

    task automatic load_stream(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                               input int total);
        logic [7:0] bytes[2];
        bytes[0] = b0;
        bytes[1] = b1;
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(bytes[i]);
        for (int i = 0; i < total; i++) exp_q.push_back(wire_bit(bytes[i / 8], i % 8));
    endtask

    task automatic pulse_start(input int total);
        @(posedge clk); #2;
        start = 1'b1;
        total_bits = CNT_W'(total);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'(0), 32'(1));
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic end_checks(input string tag, input int total, input int nbytes);
        check({tag, "_xfers"}, 32'(xfers), 32'(total));
        check({tag, "_rd"}, 32'(rd_cnt), 32'(nbytes));
        check({tag, "_done"}, 32'(done_cnt), 32'(1));
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'(0));
        check({tag, "_busy_end"}, 32'(busy), 32'(0));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 32'(bit_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ren", 32'(fifo_r_en), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        n_rst = 1'b1;
        dict_ready = 1'b1;

        // 1. reset mid-SHIFT
        clear_stats();
        ready_mode = 2;
        load_stream(8'hA5, 8'h00, 1, 8);
        pulse_start(8);
        n = 0;
        while (!bit_valid && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("t1_valid_up", 32'(bit_valid), 32'(1));
        n_rst = 1'b0;
        @(posedge clk); #2;
        check("t1_valid", 32'(bit_valid), 32'(0));
        check("t1_busy", 32'(busy), 32'(0));
        check("t1_ren", 32'(fifo_r_en), 32'(0));
        check("t1_state", 32'(state), 32'(0));
        repeat (2) @(posedge clk);
        #2;
        n_rst = 1'b1;
        fifo_q.delete();
        clear_stats();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("t1_no_rd_after", 32'(rd_cnt), 32'(0));

        // 2. basic stream 0xA5, 8 bits back to back
        clear_stats();
        load_stream(8'hA5, 8'h00, 1, 8);
        pulse_start(8);
        wait_done(100);
        end_checks("t2", 8, 1);
        check("t2_back_to_back", 32'(last_xfer_cyc - first_xfer_cyc), 32'(7));

        // 3. partial last byte
        clear_stats();
        load_stream(8'hFF, 8'h03, 2, 10);
        pulse_start(10);
        wait_done(100);
        end_checks("t3", 10, 2);
        check("t3_done_after_last", 32'(done_cyc > last_xfer_cyc), 32'(1));

        // 4. backpressure on 0x5A
        clear_stats();
        ready_mode = 1;
        load_stream(8'h5A, 8'h00, 1, 8);
        pulse_start(8);
        wait_done(200);
        end_checks("t4", 8, 1);
        ready_mode = 0;

        // 5. dictionary wait, then empty FIFO stall
        clear_stats();
        dict_ready = 1'b0;
        pulse_start(8);
        repeat (20) @(posedge clk);
        #2;
        check("t5_dict_rd", 32'(rd_cnt), 32'(0));
        check("t5_dict_state", 32'(state), 32'(1));
        check("t5_dict_busy", 32'(busy), 32'(1));
        dict_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("t5_stall_rd", 32'(rd_cnt), 32'(0));
        check("t5_stall_state", 32'(state), 32'(2));
        load_stream(8'hC3, 8'h00, 1, 8);
        wait_done(100);
        end_checks("t5", 8, 1);
        check("t5_ren_latency", 32'(last_rd_cyc - fall_cyc), 32'(1));

        // 6a. zero-length stream
        clear_stats();
        pulse_start(0);
        wait_done(20);
        end_checks("t6_zero", 0, 0);

        // 6b. start while busy is ignored
        clear_stats();
        load_stream(8'h12, 8'h34, 2, 16);
        pulse_start(16);
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1;
        total_bits = CNT_W'(3);
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(100);
        end_checks("t6_busy_start", 16, 2);

        // 6c. 0x01 bit order
        clear_stats();
        load_stream(8'h01, 8'h00, 1, 8);
        pulse_start(8);
        wait_done(100);
        end_checks("t6_01", 8, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
